flash_boot_loader: RTL



---
 rtl/flash_boot_loader_pkg.sv | 20 ++
 rtl/flash_boot_loader_spi_bit_engine.sv | 51 +++++
 rtl/flash_boot_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_boot_loader_pkg.sv
// Shared definitions for the boot-time flash-to-RAM copier.
package boot_pkg;

    localparam logic [7:0]  SPI_READ_OPC = 8'h03;
    localparam int unsigned CMD_BITS     = 32;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } boot_state_t;

    // Flash bytes arrive first-byte-first; RAM words are little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_boot_loader_spi_bit_engine.sv
// SCK generator: divides clk into SCK half-periods and flags the cycle in
// which SCK is about to rise or fall. SCK parks low whenever run is 0.
module spi_bit_engine #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] div_q, div_d;
    logic        sck_q, sck_d;

    // Half-period counter and SCK toggle decision.
    always_comb begin
        div_d     = div_q;
        sck_d     = sck_q;
        rise_tick = 1'b0;
        fall_tick = 1'b0;
        if (!run) begin
            div_d = 16'd0;
            sck_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d     = 16'd0;
            sck_d     = ~sck_q;
            rise_tick = ~sck_q;
            fall_tick = sck_q;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Divider and SCK state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= 16'd0;
            sck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/flash_boot_loader.sv
// Boot copier: reads an image from SPI flash with one READ command and
// writes it word by word into RAM, holding the CPU until the copy is done.
module flash_boot_loader
    import boot_pkg::*;
#(
    parameter logic [23:0]  FLASH_BASE = 24'h100000,
    parameter logic [31:0]  RAM_BASE   = 32'h80000000,
    parameter int unsigned  WORDS      = 4096,
    parameter int unsigned  CLK_DIV    = 2,
    parameter int unsigned  CS_DELAY   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flashMiso,
    output logic        flashClk,
    output logic        flashMosi,
    output logic        flashCs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        done,
    output logic        cpu_hold
);

    localparam logic [31:0] CMD_WORD  = {SPI_READ_OPC, FLASH_BASE};
    localparam logic [31:0] LAST_WORD = 32'(WORDS - 1);
    localparam logic [31:0] WAIT_LAST = (CS_DELAY == 0) ? 32'd0 : 32'(CS_DELAY - 1);
    localparam logic [4:0]  LAST_BIT  = 5'(CMD_BITS - 1);

    boot_state_t state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] cmd_q, cmd_d;
    logic [31:0] sr_q, sr_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        pend_q, pend_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;

    logic        sck_s, rise_s, fall_s, run_s, buf_free_s;
    logic [31:0] shift_s;

    // A completed word waiting on a full buffer lets SCK finish its high
    // phase, then parks it low until the buffer drains.
    assign run_s      = ((state_q == ST_CMD) || (state_q == ST_DATA)) && !(pend_q && !sck_s);
    assign buf_free_s = !mem_we_q || mem_ready;
    assign shift_s    = {sr_q[30:0], flashMiso};

    spi_bit_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .reset     (reset),
        .run       (run_s),
        .sck       (sck_s),
        .rise_tick (rise_s),
        .fall_tick (fall_s)
    );

    // Next-state logic: FSM, shift registers, counters and write buffer.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        sr_d        = sr_q;
        word_cnt_d  = word_cnt_q;
        next_addr_d = next_addr_q;
        pend_d      = pend_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;

        if (mem_we_q && mem_ready) begin
            mem_we_d = 1'b0;
        end else begin
            mem_we_d = mem_we_q;
        end

        // A stalled word moves into the buffer as soon as it frees up.
        if (pend_q && buf_free_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = next_addr_q;
            mem_wdata_d = bswap32(sr_q);
            next_addr_d = next_addr_q + 32'd4;
            pend_d      = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        // MOSI only moves on the falling edge; zeros follow the command.
        if (fall_s) begin
            mosi_d = cmd_q[31];
            cmd_d  = {cmd_q[30:0], 1'b0};
        end else begin
            cmd_d = cmd_q;
        end

        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q >= WAIT_LAST) begin
                    state_d   = ST_CMD;
                    cs_d      = 1'b0;
                    mosi_d    = CMD_WORD[31];
                    cmd_d     = {CMD_WORD[30:0], 1'b0};
                    bit_cnt_d = 5'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_CMD: begin
                if (rise_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 5'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_DATA: begin
                if (rise_s) begin
                    sr_d = shift_s;
                    if (bit_cnt_q == 5'd31) begin
                        bit_cnt_d  = 5'd0;
                        word_cnt_d = word_cnt_q + 32'd1;
                        if (buf_free_s) begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = next_addr_q;
                            mem_wdata_d = bswap32(shift_s);
                            next_addr_d = next_addr_q + 32'd4;
                        end else begin
                            pend_d = 1'b1;
                        end
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = ST_FLUSH;
                            cs_d    = 1'b1;
                            mosi_d  = 1'b0;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    sr_d = sr_q;
                end
            end
            ST_FLUSH: begin
                if (!pend_q && buf_free_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State and datapath registers; reset aborts any flash access at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_WAIT;
            wait_cnt_q  <= 32'd0;
            bit_cnt_q   <= 5'd0;
            cmd_q       <= 32'd0;
            sr_q        <= 32'd0;
            word_cnt_q  <= 32'd0;
            next_addr_q <= RAM_BASE;
            pend_q      <= 1'b0;
            cs_q        <= 1'b1;
            mosi_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            sr_q        <= sr_d;
            word_cnt_q  <= word_cnt_d;
            next_addr_q <= next_addr_d;
            pend_q      <= pend_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    assign flashClk  = sck_s;
    assign flashMosi = mosi_q;
    assign flashCs   = cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign cpu_hold  = ~done_q;

endmodule
